// File: rtl/mram_if.sv
// Parallel MRAM control/data bus: controller drives strobes and write data,
// responder returns read data, output-enable and error pulse.
interface mram_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  chip_en;
  logic                  write_en;
  logic                  out_en;
  logic                  lower_byte_en;
  logic                  upper_byte_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_oe;
  logic                  access_err;

  modport master (
    output addr, data_in, chip_en, write_en, out_en, lower_byte_en, upper_byte_en,
    input  data_out, data_oe, access_err
  );

  modport slave (
    input  addr, data_in, chip_en, write_en, out_en, lower_byte_en, upper_byte_en,
    output data_out, data_oe, access_err
  );
endinterface

// File: rtl/mram_responder.sv
// Cycle-level MRAM device model: byte-masked writes into local storage and
// reads returned after a fixed latency, with conflict detection.
module mram_responder #(
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MEM_DEPTH_LOG2 = 8,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic  clk,
  input  logic  rst,
  mram_if.slave bus
);
  localparam int unsigned MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned BYTE_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [MEM_DEPTH_LOG2-1:0] cap_idx, cap_idx_nxt;
  logic [DATA_WIDTH-1:0]     data_out_nxt;
  logic                      data_oe_nxt;
  logic                      access_err_nxt;

  logic [BYTE_W-1:0] mem_lo [MEM_DEPTH];
  logic [BYTE_W-1:0] mem_hi [MEM_DEPTH];

  logic [MEM_DEPTH_LOG2-1:0] idx_c;
  logic                      wr_c;
  logic                      rd_c;
  logic                      conflict_c;
  logic [DATA_WIDTH-1:0]     rd_word_c;
  logic                      unused_addr_hi;

  assign idx_c          = bus.addr[MEM_DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^bus.addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2];
  assign wr_c           = !bus.chip_en && !bus.write_en;
  assign rd_c           = !bus.chip_en && !bus.out_en && bus.write_en;
  assign conflict_c     = wr_c && !bus.out_en;

  // Disabled lanes read back as zero; lanes are re-evaluated every cycle.
  assign rd_word_c = {bus.upper_byte_en ? BYTE_W'(0) : mem_hi[cap_idx],
                      bus.lower_byte_en ? BYTE_W'(0) : mem_lo[cap_idx]};

  // Storage is never cleared; a write edge coinciding with reset is dropped.
  always_ff @(posedge clk or posedge rst) begin : mem_write
    if (!rst && wr_c) begin
      if (!bus.lower_byte_en) mem_lo[idx_c] <= bus.data_in[BYTE_W-1:0];
      if (!bus.upper_byte_en) mem_hi[idx_c] <= bus.data_in[DATA_WIDTH-1:BYTE_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_regs
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      cap_idx        <= '0;
      bus.data_out   <= '0;
      bus.data_oe    <= 1'b0;
      bus.access_err <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      cap_idx        <= cap_idx_nxt;
      bus.data_out   <= data_out_nxt;
      bus.data_oe    <= data_oe_nxt;
      bus.access_err <= access_err_nxt;
    end
  end

  always_comb begin : fsm_next
    state_nxt      = state;
    cnt_nxt        = cnt;
    cap_idx_nxt    = cap_idx;
    data_out_nxt   = '0;
    data_oe_nxt    = 1'b0;
    access_err_nxt = 1'b0;

    if (conflict_c) begin
      // Write wins; the read request is abandoned.
      state_nxt      = ST_IDLE;
      access_err_nxt = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rd_c) begin
            cap_idx_nxt = idx_c;
            cnt_nxt     = CNT_LOAD;
            state_nxt   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!rd_c) begin
            state_nxt = ST_IDLE;
          end else if (cnt == '0) begin
            data_out_nxt = rd_word_c;
            data_oe_nxt  = 1'b1;
            state_nxt    = ST_DRIVE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (!rd_c) begin
            state_nxt = ST_IDLE;
          end else if (idx_c != cap_idx) begin
            // New address under a held strobe pays the full latency again.
            cap_idx_nxt = idx_c;
            cnt_nxt     = CNT_LOAD;
            state_nxt   = ST_WAIT;
          end else begin
            data_out_nxt = rd_word_c;
            data_oe_nxt  = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end
endmodule
